ip_amba_apb_master: RTL and testbench

IP_AMBA_APB_MASTER -- requirements
Module: ip_amba_apb_master

---
 rtl/ip_amba_apb_master.sv | 154 +++++++++++++++
 tb/tb_ip_amba_apb_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_amba_apb_master.sv
// APB master: turns a valid/ready command into one APB SETUP/ACCESS transfer and
// returns a single-cycle response, with a wait-state timeout and slave-index check.
module ip_amba_apb_master #(
    parameter int PADDR_width = 32,
    parameter int PDATA_width = 32,
    parameter int PSTRB_width = PDATA_width / 8,
    parameter int PSELx_width = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [PADDR_width-1:0] cmd_addr,
    input  logic [PDATA_width-1:0] cmd_wdata,
    input  logic [PSTRB_width-1:0] cmd_strb,
    input  logic [2:0]             cmd_prot,
    input  logic [((PSELx_width > 1) ? $clog2(PSELx_width) : 1)-1:0] cmd_sel,
    output logic                   rsp_valid,
    output logic [PDATA_width-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic [PADDR_width-1:0] PADDR,
    output logic [2:0]             PPROT,
    output logic [PSELx_width-1:0] PSELx,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [PDATA_width-1:0] PWDATA,
    output logic [PSTRB_width-1:0] PSTRB,
    input  logic                   PREADY,
    input  logic [PDATA_width-1:0] PRDATA,
    input  logic                   PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic [PDATA_width-1:0] rsp_rdata_q;
    logic                   rsp_err_q;
    logic                   rsp_timeout_q;
    logic [PADDR_width-1:0] paddr_q;
    logic [2:0]             pprot_q;
    logic [PSELx_width-1:0] psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [PDATA_width-1:0] pwdata_q;
    logic [PSTRB_width-1:0] pstrb_q;
    logic [15:0]            wait_q;

    logic accept_s;
    logic sel_ok_s;
    logic wait_last_s;

    assign accept_s    = cmd_valid && cmd_ready_q;
    assign sel_ok_s    = (32'(cmd_sel) < 32'(PSELx_width));
    // The abort fires on the wait cycle that brings the count up to TIMEOUT.
    assign wait_last_s = (wait_q == 16'(TIMEOUT - 1));

    // Transfer sequencer; every output is a register written here.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {PDATA_width{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= {PADDR_width{1'b0}};
            pprot_q       <= 3'd0;
            psel_q        <= {PSELx_width{1'b0}};
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= {PDATA_width{1'b0}};
            pstrb_q       <= {PSTRB_width{1'b0}};
            wait_q        <= 16'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && sel_ok_s) begin
                        state_q     <= ST_SETUP;
                        cmd_ready_q <= 1'b0;
                        paddr_q     <= cmd_addr;
                        pprot_q     <= cmd_prot;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_write ? cmd_wdata : {PDATA_width{1'b0}};
                        pstrb_q     <= cmd_write ? cmd_strb : {PSTRB_width{1'b0}};
                        psel_q      <= PSELx_width'(1'b1) << cmd_sel;
                    end else if (accept_s) begin
                        // Out-of-range slave: answer with an error, never touch the bus.
                        cmd_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= {PDATA_width{1'b0}};
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= 16'd0;
                end
                ST_ACCESS: begin
                    if (PREADY || wait_last_s) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        psel_q        <= {PSELx_width{1'b0}};
                        penable_q     <= 1'b0;
                        pwdata_q      <= {PDATA_width{1'b0}};
                        pstrb_q       <= {PSTRB_width{1'b0}};
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= PREADY ? PSLVERR : 1'b1;
                        rsp_timeout_q <= !PREADY;
                        rsp_rdata_q   <= (PREADY && !pwrite_q) ? PRDATA : {PDATA_width{1'b0}};
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    psel_q      <= {PSELx_width{1'b0}};
                    penable_q   <= 1'b0;
                    pwdata_q    <= {PDATA_width{1'b0}};
                    pstrb_q     <= {PSTRB_width{1'b0}};
                    wait_q      <= 16'd0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PADDR       = paddr_q;
    assign PPROT       = pprot_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_ip_amba_apb_master.sv
// Bench for ip_amba_apb_master: directed cases followed by random transfers, each
// checked cycle by cycle against the expected response latency and bus contents.
module tb_ip_amba_apb_master;

    localparam int NS  = 5;
    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_strb = 4'd0;
    logic [2:0]  cmd_prot = 3'd0;
    logic [2:0]  cmd_sel = 3'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic [2:0]  PPROT;
    logic [NS-1:0] PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA = 32'd0;
    logic        PSLVERR = 1'b0;

    int          nerr = 0;
    int          nchk = 0;
    logic [31:0] last_addr = 32'd0;

    ip_amba_apb_master #(
        .PADDR_width(32), .PDATA_width(32), .PSTRB_width(4),
        .PSELx_width(NS), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic garbage();
        PREADY  = 1'($urandom);
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_psel"}, 64'(PSELx), 64'd0);
        chk({tag, "_pen"}, 64'(PENABLE), 64'd0);
        chk({tag, "_pwdata"}, 64'(PWDATA), 64'd0);
        chk({tag, "_pstrb"}, 64'(PSTRB), 64'd0);
        chk({tag, "_paddr"}, 64'(PADDR), 64'(last_addr));
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            garbage();
            @(negedge PCLK);
            chk("idle_ready", 64'(cmd_ready), 64'd1);
            chk("idle_rspv", 64'(rsp_valid), 64'd0);
            chk_idle_bus("idle");
        end
    endtask

    // One command; ready_at = ACCESS cycle (1-based) in which PREADY rises, beyond TMO = never.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input logic [2:0] sel,
                        input int ready_at, input bit slverr, input logic [31:0] rdata);
        bit          bad;
        int          lat;
        bit          e_err;
        bit          e_to;
        logic [31:0] e_rdata;
        logic [NS-1:0] e_sel;
        bad = (int'(sel) >= NS);
        if (bad) begin
            lat = 1; e_err = 1'b1; e_to = 1'b0; e_rdata = 32'd0;
        end else if (ready_at >= 1 && ready_at <= TMO) begin
            lat = ready_at + 2; e_err = slverr; e_to = 1'b0; e_rdata = wr ? 32'd0 : rdata;
        end else begin
            lat = TMO + 2; e_err = 1'b1; e_to = 1'b1; e_rdata = 32'd0;
        end
        e_sel = bad ? '0 : (NS'(1) << sel);
        chk("acc_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_strb = strb; cmd_prot = prot; cmd_sel = sel;
        garbage();
        for (int c = 1; c <= lat; c++) begin
            @(negedge PCLK);
            if (c < lat) begin
                chk("busy_ready", 64'(cmd_ready), 64'd0);
                chk("busy_rspv", 64'(rsp_valid), 64'd0);
                chk("busy_psel", 64'(PSELx), 64'(e_sel));
                chk("busy_pen", 64'(PENABLE), 64'(c >= 2));
                chk("busy_paddr", 64'(PADDR), 64'(addr));
                chk("busy_pwrite", 64'(PWRITE), 64'(wr));
                chk("busy_pprot", 64'(PPROT), 64'(prot));
                chk("busy_pwdata", 64'(PWDATA), 64'(wr ? wdata : 32'd0));
                chk("busy_pstrb", 64'(PSTRB), 64'(wr ? strb : 4'd0));
                cmd_valid = 1'(1'($urandom));
                cmd_sel   = 3'($urandom);
                garbage();
                if (c >= 2) begin
                    PREADY = (c - 1 == ready_at);
                    if (PREADY) begin
                        PRDATA  = rdata;
                        PSLVERR = slverr;
                    end
                end
            end else begin
                if (!bad) last_addr = addr;
                chk("rsp_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_err", 64'(rsp_err), 64'(e_err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
                chk("rsp_ready", 64'(cmd_ready), 64'd1);
                chk_idle_bus("rsp");
                cmd_valid = 1'b0;
                garbage();
            end
        end
    endtask

    initial begin
        @(negedge PCLK);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk_idle_bus("rst");
        PRESET = 1'b0;
        idle(2);

        xfer(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3'd0, 3'd1, 1, 1'b0, 32'd0);
        idle(1);
        xfer(1'b0, 32'h20, 32'hDEAD_BEEF, 4'hF, 3'd2, 3'd0, 3, 1'b0, 32'h1234_5678);
        idle(1);
        xfer(1'b1, 32'h30, 32'h0000_00FF, 4'h1, 3'd1, 3'd3, 1, 1'b1, 32'd0);
        idle(1);
        xfer(1'b0, 32'h40, 32'd0, 4'h0, 3'd0, 3'd2, 99, 1'b0, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h44, 32'd0, 4'h0, 3'd0, 3'd2, TMO, 1'b0, 32'hCAFE_F00D);
        idle(1);
        xfer(1'b1, 32'h50, 32'h1111_2222, 4'h3, 3'd0, 3'(NS), 1, 1'b0, 32'd0);
        xfer(1'b1, 32'h54, 32'h3333_4444, 4'hC, 3'd4, 3'd4, 1, 1'b0, 32'd0);
        xfer(1'b0, 32'h58, 32'd0, 4'h0, 3'd5, 3'd0, 2, 1'b0, 32'h5555_6666);

        // Reset while PENABLE is high: outputs clear at once and no response follows.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h7777_8888;
        cmd_strb = 4'hF; cmd_sel = 3'd2; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_pen", 64'(PENABLE), 64'd1);
        #2 PRESET = 1'b1;
        #1;
        last_addr = 32'd0;
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_rspv", 64'(rsp_valid), 64'd0);
        chk_idle_bus("mid_rst");
        @(negedge PCLK);
        PRESET = 1'b0;
        idle(3);
        xfer(1'b1, 32'h64, 32'h9999_AAAA, 4'h5, 3'd3, 3'd1, 1, 1'b0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 3'($urandom_range(0, 7)), int'($urandom_range(1, 6)), 1'($urandom), $urandom);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
